// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for simultaneous I/D requests. Define MEM_ARB_ROUND_ROBIN_EN for
// alternation; otherwise D has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    i_req_i,
    input  logic    i_req_d,
    input  req_id_t i_last_grant,
    output logic    o_grant_valid,
    output req_id_t o_grant_id
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    logic w_unused_last;
    assign w_unused_last = i_last_grant;
`endif

    // Choose which requester the FSM grants out of IDLE
    always_comb begin
        o_grant_valid = i_req_i | i_req_d;
        o_grant_id    = REQ_D;
        if (i_req_i && i_req_d) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            o_grant_id = (i_last_grant == REQ_I) ? REQ_D : REQ_I;
`else
            o_grant_id = REQ_D;
`endif
        end else if (i_req_i) begin
            o_grant_id = REQ_I;
        end else begin
            o_grant_id = REQ_D;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon-MM memory port between instruction and data masters.
// Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic [31:0] i_readdata,
    output logic        i_waitrequest,
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_readdata,
    output logic        d_waitrequest,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        bus_error
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_t    r_state;
    req_id_t       r_last_grant;
    logic [CW-1:0] r_cnt;
    logic          r_bus_error;

    logic    w_grant_valid;
    req_id_t w_grant_id;
    logic    w_granted;
    logic    w_mem_req;
    logic    w_done;
    logic    w_abandon;
    logic    w_timeout;

    mem_arb_pick u_pick (
        .i_req_i       (i_read),
        .i_req_d       (d_read | d_write),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // Forward the granted master onto the memory port; a write wins over a read
    always_comb begin
        mem_address    = 32'h0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = 32'h0;
        mem_byteenable = 4'h0;
        case (r_state)
            ARB_GNT_I: begin
                mem_address    = i_address;
                mem_read       = i_read;
                mem_byteenable = 4'hF;
            end
            ARB_GNT_D: begin
                mem_address    = d_address;
                mem_read       = d_read & ~d_write;
                mem_write      = d_write;
                mem_writedata  = d_writedata;
                mem_byteenable = d_byteenable;
            end
            default: begin
                mem_address = 32'h0;
            end
        endcase
    end

    assign w_granted = (r_state == ARB_GNT_I) || (r_state == ARB_GNT_D);
    assign w_mem_req = mem_read | mem_write;
    assign w_done    = w_granted & w_mem_req & ~mem_waitrequest;
    assign w_abandon = w_granted & ~w_mem_req;
    assign w_timeout = w_granted & w_mem_req & mem_waitrequest & (r_cnt == CNT_LAST);
    assign bus_error = r_bus_error;

    // Return path; a timeout releases the master with the error pattern
    always_comb begin
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        i_readdata    = 32'h0;
        d_readdata    = 32'h0;
        case (r_state)
            ARB_GNT_I: begin
                i_waitrequest = mem_waitrequest & ~w_timeout;
                i_readdata    = w_timeout ? ARB_ERR_DATA : mem_readdata;
            end
            ARB_GNT_D: begin
                d_waitrequest = mem_waitrequest & ~w_timeout;
                d_readdata    = w_timeout ? ARB_ERR_DATA : mem_readdata;
            end
            default: begin
                i_waitrequest = 1'b1;
            end
        endcase
    end

    // Grant FSM with stall counter; every exit from a grant passes through IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= REQ_I;
            r_cnt        <= {CW{1'b0}};
            r_bus_error  <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_cnt <= {CW{1'b0}};
                    if (w_grant_valid) begin
                        r_state <= (w_grant_id == REQ_D) ? ARB_GNT_D : ARB_GNT_I;
                    end else begin
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_GNT_I, ARB_GNT_D: begin
                    if (w_done) begin
                        r_state      <= ARB_IDLE;
                        r_cnt        <= {CW{1'b0}};
                        r_last_grant <= (r_state == ARB_GNT_D) ? REQ_D : REQ_I;
                    end else if (w_abandon) begin
                        r_state <= ARB_IDLE;
                        r_cnt   <= {CW{1'b0}};
                    end else if (w_timeout) begin
                        r_state     <= ARB_IDLE;
                        r_cnt       <= {CW{1'b0}};
                        r_bus_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_cnt   <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: drivers queue expected responses, a negedge
// monitor checks each completed handshake against a shadow-memory model.
module tb_mem_bus_arbiter;

    localparam logic [31:0] BASE = 32'hBFC0_0000;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_address, i_readdata, d_address, d_writedata, d_readdata;
    logic        i_read, i_waitrequest, d_read, d_write, d_waitrequest;
    logic [3:0]  d_byteenable, mem_byteenable;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write, mem_waitrequest, bus_error;

    int checks   = 0;
    int failures = 0;

    item_t      q_i[$];
    item_t      q_d[$];
    item_t      mon_it;
    logic [7:0] grant_log[$];
    logic [31:0] shadow [0:255];

    logic        stall    = 1'b0;
    int          cfg_wait = -1;
    int          ram_cnt  = 0;
    int          ram_need = 0;
    logic [31:0] ram_x [0:255] = '{default: 32'h0};

    mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read), .i_readdata(i_readdata), .i_waitrequest(i_waitrequest),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
        .d_byteenable(d_byteenable), .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [7:0] idx);
        return {8'hC5, idx, ~idx, idx ^ 8'h3C};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // RAM model: fixed or random wait states, optional permanent stall
    assign mem_readdata    = ram_x[mem_address[9:2]] ^ pat(mem_address[9:2]);
    assign mem_waitrequest = stall || ((mem_read || mem_write) &&
                             (ram_cnt < ((cfg_wait >= 0) ? cfg_wait : ram_need)));

    always @(posedge clk) begin
        if (mem_read || mem_write) begin
            if (!mem_waitrequest) begin
                if (mem_write)
                    ram_x[mem_address[9:2]] <= merge(mem_readdata, mem_writedata, mem_byteenable)
                                               ^ pat(mem_address[9:2]);
                ram_cnt  <= 0;
                ram_need <= int'($urandom_range(0, 4));
            end else begin
                ram_cnt <= ram_cnt + 1;
            end
        end else begin
            ram_cnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every completed handshake is checked against the head of its queue
    always @(negedge clk) begin
        if (!reset) begin
            chk("single_grant", {31'h0, (!i_waitrequest && !d_waitrequest)}, 32'h0);
            if (i_read && !i_waitrequest) begin
                grant_log.push_back(8'h49);
                if (q_i.size() == 0) note_fail("i_unexpected_ack");
                else begin
                    mon_it = q_i.pop_front();
                    chk("i_readdata", i_readdata, mon_it.rdata);
                    chk("i_mem_address", mem_address, mon_it.addr);
                    chk("i_mem_rw", {30'h0, mem_read, mem_write}, 32'h2);
                    chk("i_mem_be", {28'h0, mem_byteenable}, 32'hF);
                    chk("d_readdata_idle", d_readdata, 32'h0);
                end
            end
            if ((d_read || d_write) && !d_waitrequest) begin
                grant_log.push_back(8'h44);
                if (q_d.size() == 0) note_fail("d_unexpected_ack");
                else begin
                    mon_it = q_d.pop_front();
                    chk("d_mem_address", mem_address, mon_it.addr);
                    chk("d_mem_rw", {30'h0, mem_read, mem_write}, mon_it.wr ? 32'h1 : 32'h2);
                    chk("d_mem_be", {28'h0, mem_byteenable}, {28'h0, mon_it.be});
                    if (mon_it.wr) chk("d_mem_writedata", mem_writedata, mon_it.wdata);
                    else           chk("d_readdata", d_readdata, mon_it.rdata);
                    chk("i_readdata_idle", i_readdata, 32'h0);
                end
            end
        end
    end

    task automatic i_xfer(input logic [31:0] addr, input bit expect_err,
                          output int n_cyc, output int n_rd);
        item_t it;
        bit    done;
        it.addr  = addr;
        it.wr    = 1'b0;
        it.wdata = 32'h0;
        it.be    = 4'hF;
        it.rdata = expect_err ? ERR : shadow[addr[9:2]];
        q_i.push_back(it);
        i_address = addr;
        i_read    = 1'b1;
        n_cyc = 0; n_rd = 0; done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            n_cyc++;
            if (mem_read) n_rd++;
            if (!i_waitrequest) done = 1'b1;
        end
        if (!done) begin
            note_fail("i_handshake_bound");
            void'(q_i.pop_back());
        end
        @(posedge clk); #1;
        i_read = 1'b0;
    endtask

    task automatic d_xfer(input logic [31:0] addr, input logic rd, input logic wr,
                          input logic [31:0] wd, input logic [3:0] be);
        item_t it;
        bit    done;
        it.addr  = addr;
        it.wr    = wr;
        it.wdata = wd;
        it.be    = be;
        it.rdata = shadow[addr[9:2]];
        if (wr) shadow[addr[9:2]] = merge(shadow[addr[9:2]], wd, be);
        q_d.push_back(it);
        d_address = addr; d_read = rd; d_write = wr; d_writedata = wd; d_byteenable = be;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (!d_waitrequest) done = 1'b1;
        end
        if (!done) begin
            note_fail("d_handshake_bound");
            void'(q_d.pop_back());
        end
        @(posedge clk); #1;
        d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic check_log(input string name, input string exp_s);
        chk({name, "_len"}, grant_log.size(), exp_s.len());
        for (int k = 0; k < exp_s.len() && k < grant_log.size(); k++)
            chk(name, {24'h0, grant_log[k]}, {24'h0, exp_s[k]});
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc, nr;
        string exp_s;
        for (int i = 0; i < 256; i++) shadow[i] = pat(8'(i));
        reset = 1'b1;
        i_address = 32'h0; i_read = 1'b0;
        d_address = 32'h0; d_read = 1'b0; d_write = 1'b0; d_writedata = 32'h0; d_byteenable = 4'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_i_wait", {31'h0, i_waitrequest}, 32'h1);
        chk("rst_d_wait", {31'h0, d_waitrequest}, 32'h1);
        chk("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_mem_addr_be", mem_address | {28'h0, mem_byteenable}, 32'h0);
        chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
        chk("rst_readdata", i_readdata | d_readdata, 32'h0);
        @(posedge clk); #1;

        // Single I read with one RAM wait state
        cfg_wait = 1;
        i_xfer(BASE, 1'b0, nc, nr);
        chk("t1_mem_read_cycles", nr, 2);
        chk("t1_latency", nc, 3);
        @(negedge clk);
        chk("t1_turnaround_rd", {31'h0, mem_read}, 32'h0);
        chk("t1_turnaround_wait", {31'h0, i_waitrequest}, 32'h1);
        cfg_wait = -1;
        @(posedge clk); #1;

        // D writes (full and partial byte enables) and read-backs
        d_xfer(BASE + 32'h10, 1'b0, 1'b1, 32'h1234_5678, 4'hF);
        i_xfer(BASE + 32'h10, 1'b0, nc, nr);
        d_xfer(BASE + 32'h204, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0101);
        d_xfer(BASE + 32'h204, 1'b1, 1'b0, 32'h0, 4'hF);

        // D read+write together while I queues behind it
        grant_log.delete();
        fork
            d_xfer(BASE + 32'h20, 1'b1, 1'b1, 32'hCAFE_F00D, 4'hF);
            begin @(posedge clk); #1; i_xfer(BASE + 32'h20, 1'b0, nc, nr); end
        join
        check_log("t6_order", "DI");

        // Granted master withdraws its request mid-wait
        stall = 1'b1;
        i_address = BASE + 32'h44; i_read = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 i_read = 1'b0;
        @(negedge clk);
        chk("abandon_mem_read", {31'h0, mem_read}, 32'h0);
        @(negedge clk);
        chk("abandon_no_error", {31'h0, bus_error}, 32'h0);
        @(posedge clk); #1;

        // Timeout abort on a permanently stalled RAM
        i_xfer(BASE + 32'h40, 1'b1, nc, nr);
        chk("t4_grant_cycles", nr, 8);
        chk("t4_latency", nc, 9);
        @(negedge clk);
        chk("t4_bus_error_set", {31'h0, bus_error}, 32'h1);
        stall = 1'b0;
        @(posedge clk); #1;
        d_xfer(BASE + 32'h208, 1'b0, 1'b1, 32'h0BAD_F00D, 4'hF);
        i_xfer(BASE + 32'h48, 1'b0, nc, nr);
        @(negedge clk);
        chk("t4_bus_error_sticky", {31'h0, bus_error}, 32'h1);

        // Synchronous reset while D is stalled in its grant
        @(posedge clk); #1;
        stall = 1'b1;
        d_address = BASE + 32'h300; d_writedata = 32'h5555_AAAA; d_byteenable = 4'hF;
        d_read = 1'b0; d_write = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("t5_pre_edge_mem_write", {31'h0, mem_write}, 32'h1);
        @(negedge clk);
        chk("t5_mem_write", {31'h0, mem_write}, 32'h0);
        chk("t5_waits", {30'h0, i_waitrequest, d_waitrequest}, 32'h3);
        chk("t5_bus_error", {31'h0, bus_error}, 32'h0);
        d_write = 1'b0;
        stall = 1'b0;
        @(posedge clk); #1 reset = 1'b0;

        // Simultaneous requests straight out of reset
        grant_log.delete();
        fork
            begin
                for (int n = 0; n < 4; n++)
                    d_xfer(BASE + 32'h210 + 32'(n * 4), 1'b0, 1'b1, 32'h1111_0000 + 32'(n), 4'hF);
            end
            i_xfer(BASE + 32'h60, 1'b0, nc, nr);
        join
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_s = "DIDDD";
`else
        exp_s = "DDDDI";
`endif
        check_log("t3_order", exp_s);

        // Randomised concurrent traffic in disjoint I and D regions
        fork
            begin
                int n_c, n_r;
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    i_xfer(BASE + {22'h0, 1'b0, 7'($urandom_range(0, 127)), 2'b00}, 1'b0, n_c, n_r);
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    int op;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    op = int'($urandom_range(0, 2));
                    d_xfer(BASE + {22'h0, 1'b1, 7'($urandom_range(0, 127)), 2'b00},
                           op != 1, op != 0, $urandom, 4'($urandom_range(1, 15)));
                end
            end
        join

        @(negedge clk);
        chk("queues_drained", q_i.size() + q_d.size(), 32'h0);
        chk("final_bus_error", {31'h0, bus_error}, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
